// File: rtl/ack_bus_pkg.sv
// Shared definitions for the open-drain ACK bus: source IDs, requester state encoding
// and the bus recovery length.
package ack_bus_pkg;

    localparam int ACK_ID_W = 2;

    // Lowest ID wins arbitration on the wired-AND bus.
    localparam logic [ACK_ID_W-1:0] ACK_ID_MEM  = 2'b00;
    localparam logic [ACK_ID_W-1:0] ACK_ID_SHA  = 2'b01;
    localparam logic [ACK_ID_W-1:0] ACK_ID_AES  = 2'b10;
    localparam logic [ACK_ID_W-1:0] ACK_ID_CTRL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int ACK_GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_GAP  = ST_GAP
    } state_t;

    // A zero ID bit is driven by pulling that line low.
    function automatic logic [ACK_ID_W-1:0] id_pull_mask(input logic [ACK_ID_W-1:0] id);
        return ~id;
    endfunction

endpackage

// File: rtl/ack_bus_requester_if.sv
// Pull-down enables and arbiter handshake of one source on the shared ACK bus.
interface ack_bus_requester_if;
    import ack_bus_pkg::*;

    logic                ack_valid_n_oe;
    logic [ACK_ID_W-1:0] ack_id_oe;
    logic                req_out;
    logic                ack_ready_in;

    modport master (
        output ack_valid_n_oe,
        output ack_id_oe,
        output req_out,
        input  ack_ready_in
    );

    modport slave (
        input  ack_valid_n_oe,
        input  ack_id_oe,
        input  req_out,
        output ack_ready_in
    );

endinterface

// File: rtl/ack_wait_timer.sv
// Counts cycles spent waiting for a grant; expired is high once the count reaches TIMEOUT.
module ack_wait_timer #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] count_reg;

    assign expired = (count_reg == TO_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !expired) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

endmodule

// File: rtl/ack_bus_requester.sv
// Per-source ACK bus initiator: queues completion pulses, drives its ID until granted
// (or timed out), then releases the bus for a recovery gap.
module ack_bus_requester
    import ack_bus_pkg::*;
#(
    parameter logic [ACK_ID_W-1:0] SOURCE_ID = ACK_ID_AES,
    parameter int                  PEND_W    = 2,
    parameter int                  TIMEOUT   = 255,
    parameter int                  TO_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ack_pulse,
    input  logic                err_clr,
    ack_bus_requester_if.master bus,
    output logic                ack_done,
    output logic [PEND_W-1:0]   pending,
    output logic                busy,
    output logic                err_overflow,
    output logic                err_timeout
);

    localparam int                  GAP_W   = $clog2(ACK_GAP_CYCLES + 1);
    localparam logic [ACK_ID_W-1:0] ID_MASK = id_pull_mask(SOURCE_ID);

    state_t              state_reg, state_next;
    logic [PEND_W-1:0]   pending_reg, pending_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic                ack_done_reg, drive_reg, busy_reg;
    logic                err_overflow_reg, err_timeout_reg;
    logic [ACK_ID_W-1:0] id_oe_reg;
    logic                grant, abandon, overflow, gap_last, expired;

    ack_wait_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_reg != S_REQ),
        .en      (state_reg == S_REQ),
        .expired (expired)
    );

    assign gap_last = (gap_cnt_reg == GAP_W'(ACK_GAP_CYCLES - 1));

    // Ready is honoured only in REQ, and wins over a same-cycle timeout.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = '0;
        grant        = 1'b0;
        abandon      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (pending_reg != '0) state_next = S_REQ;
            end
            S_REQ: begin
                if (bus.ack_ready_in) begin
                    grant      = 1'b1;
                    state_next = S_GAP;
                end else if (expired) begin
                    abandon    = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_next = (pending_reg != '0) ? S_REQ : S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pending_next = pending_reg;
        overflow     = 1'b0;
        if (ack_pulse && !(grant || abandon)) begin
            if (pending_reg == '1) overflow = 1'b1;
            else                   pending_next = pending_reg + PEND_W'(1);
        end else if (!ack_pulse && (grant || abandon)) begin
            pending_next = pending_reg - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            pending_reg      <= '0;
            gap_cnt_reg      <= '0;
            ack_done_reg     <= 1'b0;
            drive_reg        <= 1'b0;
            id_oe_reg        <= '0;
            busy_reg         <= 1'b0;
            err_overflow_reg <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= pending_next;
            gap_cnt_reg      <= gap_cnt_next;
            ack_done_reg     <= grant;
            drive_reg        <= (state_next == S_REQ);
            id_oe_reg        <= (state_next == S_REQ) ? ID_MASK : '0;
            busy_reg         <= (state_next != S_IDLE);
            // A new error in the same cycle as err_clr keeps the flag set.
            err_overflow_reg <= (err_overflow_reg && !err_clr) || overflow;
            err_timeout_reg  <= (err_timeout_reg && !err_clr) || abandon;
        end
    end

    assign bus.ack_valid_n_oe = drive_reg;
    assign bus.ack_id_oe      = id_oe_reg;
    assign bus.req_out        = drive_reg;
    assign ack_done           = ack_done_reg;
    assign pending            = pending_reg;
    assign busy               = busy_reg;
    assign err_overflow       = err_overflow_reg;
    assign err_timeout        = err_timeout_reg;

endmodule

// File: tb/tb_ack_bus_requester.sv
// Two requesters (mem, aes) on a modelled wired-AND bus with a lowest-ID-wins arbiter.
module tb_ack_bus_requester;
    import ack_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic pulse_mem, pulse_aes, clr_mem, clr_aes;
    logic done_mem, done_aes, busy_mem, busy_aes;
    logic ovf_mem, ovf_aes, tmo_mem, tmo_aes;
    logic [1:0] pend_mem, pend_aes;
    logic grant_en, spur_aes;
    logic [1:0] bus_id;
    logic bus_valid_n;

    int n_checks = 0;
    int n_errors = 0;

    ack_bus_requester_if bus_mem ();
    ack_bus_requester_if bus_aes ();

    always #5 clk = ~clk;

    // Open-drain bus: a line is low when any source pulls it.
    assign bus_id      = ~(bus_mem.ack_id_oe | bus_aes.ack_id_oe);
    assign bus_valid_n = ~(bus_mem.ack_valid_n_oe | bus_aes.ack_valid_n_oe);
    assign bus_mem.ack_ready_in = grant_en && !bus_valid_n && bus_mem.req_out && (bus_id == ACK_ID_MEM);
    assign bus_aes.ack_ready_in = (grant_en && !bus_valid_n && bus_aes.req_out && (bus_id == ACK_ID_AES)) || spur_aes;

    ack_bus_requester #(.SOURCE_ID(ACK_ID_MEM), .PEND_W(2), .TIMEOUT(4), .TO_W(8)) u_mem (
        .clk(clk), .rst(rst), .ack_pulse(pulse_mem), .err_clr(clr_mem), .bus(bus_mem),
        .ack_done(done_mem), .pending(pend_mem), .busy(busy_mem),
        .err_overflow(ovf_mem), .err_timeout(tmo_mem)
    );

    ack_bus_requester #(.SOURCE_ID(ACK_ID_AES), .PEND_W(2), .TIMEOUT(255), .TO_W(8)) u_aes (
        .clk(clk), .rst(rst), .ack_pulse(pulse_aes), .err_clr(clr_aes), .bus(bus_aes),
        .ack_done(done_aes), .pending(pend_aes), .busy(busy_aes),
        .err_overflow(ovf_aes), .err_timeout(tmo_aes)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int q_done [6] = '{1, 0, 1, 0, 1, 0};
    int q_pend [6] = '{2, 2, 1, 1, 0, 0};

    initial begin
        rst = 1'b1; pulse_mem = 0; pulse_aes = 0; clr_mem = 0; clr_aes = 0;
        grant_en = 1'b1; spur_aes = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst aes oe", bus_aes.ack_valid_n_oe, 0);
        check_val("rst aes id_oe", bus_aes.ack_id_oe, 0);
        check_val("rst mem req", bus_mem.req_out, 0);
        check_val("rst aes pend", pend_aes, 0);
        check_val("rst aes busy", busy_aes, 0);
        check_val("rst aes done", done_aes, 0);
        check_val("rst mem errs", {ovf_mem, tmo_mem}, 0);

        // Single ack on aes: oe at t2, done at t3, idle at t4.
        pulse_aes = 1; step(); pulse_aes = 0;
        check_val("single t1 pend", pend_aes, 1);
        check_val("single t1 oe", bus_aes.ack_valid_n_oe, 0);
        step();
        check_val("single t2 oe", bus_aes.ack_valid_n_oe, 1);
        check_val("single t2 id_oe", bus_aes.ack_id_oe, 2'b01);
        check_val("single t2 bus_id", bus_id, 2'b10);
        check_val("single t2 req", bus_aes.req_out, 1);
        step();
        check_val("single t3 done", done_aes, 1);
        check_val("single t3 pend", pend_aes, 0);
        check_val("single t3 oe", bus_aes.ack_valid_n_oe, 0);
        check_val("single t3 busy", busy_aes, 1);
        step();
        check_val("single t4 busy", busy_aes, 0);
        check_val("single t4 done", done_aes, 0);

        // Contention: mem wins, aes keeps driving and is granted during mem's gap.
        pulse_mem = 1; pulse_aes = 1; step(); pulse_mem = 0; pulse_aes = 0;
        step();
        check_val("cont t2 bus_id", bus_id, 2'b00);
        check_val("cont t2 aes oe", bus_aes.ack_valid_n_oe, 1);
        step();
        check_val("cont t3 mem done", done_mem, 1);
        check_val("cont t3 aes done", done_aes, 0);
        check_val("cont t3 aes oe", bus_aes.ack_valid_n_oe, 1);
        check_val("cont t3 bus_id", bus_id, 2'b10);
        step();
        check_val("cont t4 aes done", done_aes, 1);
        check_val("cont t4 mem pend", pend_mem, 0);
        check_val("cont t4 aes pend", pend_aes, 0);
        step(); step();

        // Queue of three, then a fourth pulse overflows.
        grant_en = 0;
        pulse_aes = 1; step(); step(); step();
        check_val("queue t3 pend", pend_aes, 3);
        check_val("queue t3 ovf", ovf_aes, 0);
        step(); pulse_aes = 0;
        check_val("queue t4 ovf", ovf_aes, 1);
        check_val("queue t4 pend", pend_aes, 3);
        grant_en = 1;
        // Granted every REQ: done in each GAP, one cycle of REQ in between.
        for (int k = 0; k < 6; k++) begin
            step();
            check_val($sformatf("queue c%0d done", k + 5), done_aes, q_done[k]);
            check_val($sformatf("queue c%0d pend", k + 5), pend_aes, q_pend[k]);
        end
        check_val("queue c10 busy", busy_aes, 0);
        clr_aes = 1; step(); clr_aes = 0;
        check_val("queue clr ovf", ovf_aes, 0);

        // Timeout on mem (TIMEOUT=4): five REQ cycles, err_clr collides with the new error.
        grant_en = 0;
        pulse_mem = 1; step(); pulse_mem = 0;
        step();
        repeat (4) step();
        check_val("tmo t6 oe", bus_mem.ack_valid_n_oe, 1);
        check_val("tmo t6 err", tmo_mem, 0);
        clr_mem = 1; step(); clr_mem = 0;
        check_val("tmo t7 err", tmo_mem, 1);
        check_val("tmo t7 oe", bus_mem.ack_valid_n_oe, 0);
        check_val("tmo t7 pend", pend_mem, 0);
        check_val("tmo t7 done", done_mem, 0);
        check_val("tmo t7 busy", busy_mem, 1);
        clr_mem = 1; step(); clr_mem = 0;
        check_val("tmo clr err", tmo_mem, 0);

        // Ready on the last allowed wait cycle is a grant.
        pulse_mem = 1; step(); pulse_mem = 0;
        step();
        repeat (4) step();
        grant_en = 1;
        step();
        check_val("edge t7 done", done_mem, 1);
        check_val("edge t7 err", tmo_mem, 0);
        check_val("edge t7 pend", pend_mem, 0);
        step(); step();

        // New pulse in the grant cycle: pending holds at 1, a second round follows.
        pulse_aes = 1; step(); pulse_aes = 0;
        step();
        pulse_aes = 1; step(); pulse_aes = 0;
        check_val("simul t3 done", done_aes, 1);
        check_val("simul t3 pend", pend_aes, 1);
        check_val("simul t3 oe", bus_aes.ack_valid_n_oe, 0);
        step();
        check_val("simul t4 oe", bus_aes.ack_valid_n_oe, 1);
        step();
        check_val("simul t5 done", done_aes, 1);
        check_val("simul t5 pend", pend_aes, 0);
        step(); step();

        // Spurious ready while idle must not decrement or complete.
        spur_aes = 1; step(); spur_aes = 0;
        check_val("spur pend", pend_aes, 0);
        check_val("spur busy", busy_aes, 0);
        step();
        check_val("spur done", done_aes, 0);

        // Reset mid-REQ clears everything without a clock edge.
        grant_en = 0;
        pulse_aes = 1; repeat (4) step(); pulse_aes = 0;
        check_val("rstreq pre oe", bus_aes.ack_valid_n_oe, 1);
        check_val("rstreq pre ovf", ovf_aes, 1);
        #3 rst = 1'b1;
        #1;
        check_val("rstreq oe", bus_aes.ack_valid_n_oe, 0);
        check_val("rstreq id_oe", bus_aes.ack_id_oe, 0);
        check_val("rstreq req", bus_aes.req_out, 0);
        check_val("rstreq pend", pend_aes, 0);
        check_val("rstreq ovf", ovf_aes, 0);
        @(posedge clk); #1 rst = 1'b0;
        grant_en = 1;
        step();
        check_val("rstreq idle busy", busy_aes, 0);
        check_val("rstreq idle oe", bus_aes.ack_valid_n_oe, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
